// File: rtl/rr_mux_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter_pkg
// Purpose : shared defaults for the round-robin mux arbiter slice.
// Contents: RR_N  - default requester count (power of two, >= 2)
//           RR_W  - default data width per requester
//           SEL_W - index width matching RR_N
// -----------------------------------------------------------------------------
package rr_mux_arbiter_pkg;

    localparam int RR_N  = 4;
    localparam int RR_W  = 4;
    localparam int SEL_W = $clog2(RR_N);

endpackage

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
// Purpose : combinational round-robin pick. Returns the first asserted request
//           at or after i_ptr, wrapping modulo N.
// Ports   : i_req         in  N   request vector
//           i_ptr         in  SW  highest-priority index
//           o_grant_valid out 1   at least one request asserted
//           o_grant_idx   out SW  winning index (meaningful when valid)
// -----------------------------------------------------------------------------
module rr_priority_select
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N  = RR_N,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic          o_grant_valid,
    output logic [SW-1:0] o_grant_idx
);

    logic [N-1:0]  w_rot;
    logic [SW-1:0] w_off;

    // Rotate so that bit 0 of w_rot is requester i_ptr. N is a power of two,
    // so the SW-bit index sum wraps modulo N for free.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = i_req[SW'(i) + i_ptr];
        end
    end

    // Lowest set bit of the rotated vector: scanning downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SW'(i);
            end
        end
    end

    assign o_grant_valid = |i_req;
    assign o_grant_idx   = w_off + i_ptr;

endmodule

// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
// Purpose : N requesters share one W-bit output register through a round-robin
//           arbiter and an N:1 mux tree. One word per cycle when drained.
// Ports   : clk        in  1      rising-edge clock
//           rst        in  1      synchronous active-high reset
//           req_valid  in  N      requester i offers word i
//           req_data   in  N*W    word i = req_data[i*W +: W]
//           req_ready  out N      one-hot or zero accept strobe
//           out_valid  out 1      output register holds a word
//           out_data   out W      registered winning word
//           out_sel    out log2N  requester that supplied out_data
//           out_ready  in  1      consumer accepts the held word
// -----------------------------------------------------------------------------
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N = RR_N,
    parameter int W = RR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_sel,
    input  logic                 out_ready
);

    localparam int SW = $clog2(N);

    logic [SW-1:0] r_ptr;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;

    logic          w_load;
    logic          w_grant_valid;
    logic [SW-1:0] w_grant_idx;
    logic [W-1:0]  w_word [N];
    logic [W-1:0]  w_sel_data;

    rr_priority_select #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .i_req         (req_valid),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // Output stage can take a word when empty or being drained this cycle.
    assign w_load    = ~r_out_valid | out_ready;
    assign req_ready = (w_grant_valid && w_load && !rst) ? (N'(1) << w_grant_idx) : '0;

    for (genvar i = 0; i < N; i++) begin : g_word
        assign w_word[i] = req_data[i*W +: W];
    end

    // Binary mux tree: level l halves the candidates using grant bit l, so
    // bit 0 picks between adjacent requesters at the first level.
    for (genvar l = 0; l < SW; l++) begin : g_lvl
        localparam int CNT = N >> (l + 1);
        logic [W-1:0] w_node [CNT];
        for (genvar j = 0; j < CNT; j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign w_node[j] = w_grant_idx[l] ? w_word[2*j+1] : w_word[2*j];
            end else begin : g_inner
                assign w_node[j] = w_grant_idx[l] ? g_lvl[l-1].w_node[2*j+1]
                                                  : g_lvl[l-1].w_node[2*j];
            end
        end
    end

    assign w_sel_data = g_lvl[SW-1].w_node[0];

    // ptr advances only on an accepted transfer; an idle load just empties
    // the output stage and leaves data/sel as they were.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_grant_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_grant_idx;
                r_ptr       <= w_grant_idx + SW'(1);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
